// File: rtl/log_mel_engine_pkg.sv
// Shared types and constants for the log-mel stage: ln2 constant,
// channel tag, FSM states and the elaboration-time log2 LUT generator.
package log_mel_engine_pkg;

  localparam logic [15:0] LN2_Q16 = 16'hB172;
  localparam int TAG_W = 8;

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  // round(65536*log2(1+k/2**bits)) by repeated squaring in Q31;
  // 24 result bits are produced and rounded to 16.
  function automatic logic [16:0] lut_val(input int k, input int bits);
    logic [63:0] y;
    logic [23:0] r;
    logic [24:0] s;
    if (k >= (1 << bits)) return 17'h10000;
    y = 64'((1 << bits) + k) << (31 - bits);
    r = '0;
    for (int i = 0; i < 24; i++) begin
      y = (y * y) >> 31;
      if (y[32]) begin
        r = {r[22:0], 1'b1};
        y = y >> 1;
      end else begin
        r = {r[22:0], 1'b0};
      end
    end
    s = {1'b0, r} + 25'd128;
    return 17'(s >> 8);
  endfunction

endpackage

// File: rtl/log_mel_engine_if.sv
// Frame bus of the log-mel stage: mel energies + start pulse in,
// log frame, zero flags, ready pulse, busy and drop error out.
interface log_mel_engine_if #(
  parameter int N_CH  = 13,
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
);
  logic [N_CH-1:0][IN_W-1:0]  mel_in;
  logic                       mel_ready;
  logic [N_CH-1:0][OUT_W-1:0] log_out;
  logic [N_CH-1:0]            zero_flag;
  logic                       log_ready;
  logic                       busy;
  logic                       drop_err;

  modport master (
    output mel_in, mel_ready,
    input  log_out, zero_flag, log_ready, busy, drop_err
  );

  modport slave (
    input  mel_in, mel_ready,
    output log_out, zero_flag, log_ready, busy, drop_err
  );
endinterface

// File: rtl/log_mel_engine_log2_ln_core.sv
// log2_ln_core: 3-stage ln pipeline (LOD -> LUT log2 -> x ln2, round, sat).
// Ports: clk, rst_n, i_valid/i_tag/i_x in; o_valid/o_tag/o_res/o_zero out.
// Build option LOG_INTERP_EN: interpolate between adjacent LUT entries.
module log2_ln_core
  import log_mel_engine_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int FRAC_W   = 8,
  parameter int LUT_BITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  tag_t             i_tag,
  input  logic [IN_W-1:0]  i_x,
  output logic             o_valid,
  output tag_t             o_tag,
  output logic [OUT_W-1:0] o_res,
  output logic             o_zero
);
  localparam int EW = $clog2(IN_W);
  localparam int LW = EW + 16;
  localparam int PW = LW + 16;
  localparam int TB = 8;
`ifdef LOG_INTERP_EN
  localparam int LUT_N = (1 << LUT_BITS) + 1;
`else
  localparam int LUT_N = 1 << LUT_BITS;
`endif

  logic [16:0] w_lut [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam logic [16:0] V = lut_val(k, LUT_BITS);
    assign w_lut[k] = V;
  end

  logic [EW-1:0]   w_e;
  logic [IN_W-1:0] w_m;
  logic            w_z;
  logic            w_unused;

  always_comb begin
    w_e = '0;
    for (int i = 0; i < IN_W; i++)
      if (i_x[i]) w_e = EW'(i);
  end

  assign w_z = ~|i_x;
  assign w_m = i_x << (EW'(IN_W - 1) - w_e);

  logic                r1_v;
  logic                r1_z;
  tag_t                r1_tag;
  logic [EW-1:0]       r1_e;
  logic [LUT_BITS-1:0] r1_k;
`ifdef LOG_INTERP_EN
  logic [TB-1:0]       r1_t;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v   <= 1'b0;
      r1_z   <= 1'b0;
      r1_tag <= '0;
      r1_e   <= '0;
      r1_k   <= '0;
`ifdef LOG_INTERP_EN
      r1_t   <= '0;
`endif
    end else begin
      r1_v   <= i_valid;
      r1_z   <= w_z;
      r1_tag <= i_tag;
      r1_e   <= w_e;
      r1_k   <= w_m[IN_W-2 -: LUT_BITS];
`ifdef LOG_INTERP_EN
      r1_t   <= w_m[IN_W-2-LUT_BITS -: TB];
`endif
    end
  end

  logic [16:0] w_f;
`ifdef LOG_INTERP_EN
  logic [LUT_BITS:0] w_ia;
  logic [LUT_BITS:0] w_ib;
  logic [16:0]       w_lo;
  logic [16:0]       w_hi;
  logic [16:0]       w_dif;
  logic [16+TB:0]    w_pr;
  assign w_ia  = {1'b0, r1_k};
  assign w_ib  = w_ia + 1'b1;
  assign w_lo  = w_lut[w_ia];
  assign w_hi  = w_lut[w_ib];
  assign w_dif = w_hi - w_lo;
  assign w_pr  = w_dif * r1_t;
  assign w_f   = w_lo + w_pr[16+TB:TB];
  assign w_unused = ^{w_m[IN_W-1], w_m[IN_W-2-LUT_BITS-TB:0],
                      w_pr[TB-1:0]};
`else
  assign w_f   = w_lut[r1_k];
  assign w_unused = ^{w_m[IN_W-1], w_m[IN_W-2-LUT_BITS:0]};
`endif

  logic          r2_v;
  logic          r2_z;
  tag_t          r2_tag;
  logic [LW-1:0] r2_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_v   <= 1'b0;
      r2_z   <= 1'b0;
      r2_tag <= '0;
      r2_l   <= '0;
    end else begin
      r2_v   <= r1_v;
      r2_z   <= r1_z;
      r2_tag <= r1_tag;
      r2_l   <= {r1_e, 16'h0} + LW'(w_f);
    end
  end

  // Q.16 log2 times Q0.16 ln2 gives Q.32; add half an output LSB first.
  logic [PW-1:0] w_p;
  logic [PW-1:0] w_q;
  logic          w_sat;
  assign w_p   = PW'(r2_l) * PW'(LN2_Q16)
               + (PW'(1) << (31 - FRAC_W));
  assign w_q   = w_p >> (32 - FRAC_W);
  assign w_sat = |w_q[PW-1:OUT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_tag   <= '0;
      o_zero  <= 1'b0;
      o_res   <= '0;
    end else begin
      o_valid <= r2_v;
      o_tag   <= r2_tag;
      o_zero  <= r2_z;
      o_res   <= r2_z  ? '0 :
                 w_sat ? '1 : w_q[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/log_mel_engine.sv
// log_mel_engine: captures N_CH mel energies, streams them through ln core.
// Ports: clk, reset_n (async, low), bus (log_mel_engine_if.slave).
// Build option LOG_INTERP_EN selects interpolated LUT in the core.
module log_mel_engine
  import log_mel_engine_pkg::*;
#(
  parameter int N_CH     = 13,
  parameter int IN_W     = 16,
  parameter int OUT_W    = 16,
  parameter int FRAC_W   = 8,
  parameter int LUT_BITS = 5
) (
  input logic             clk,
  input logic             reset_n,
  log_mel_engine_if.slave bus
);
  state_e r_state;
  state_e w_next;
  tag_t   r_cnt;

  logic [N_CH-1:0][IN_W-1:0]  r_cap;
  logic [N_CH-1:0][OUT_W-1:0] r_shd;
  logic [N_CH-1:0][OUT_W-1:0] w_shd;
  logic [N_CH-1:0][OUT_W-1:0] r_out;
  logic [N_CH-1:0]            r_zshd;
  logic [N_CH-1:0]            w_zshd;
  logic [N_CH-1:0]            r_zout;
  logic                       r_rdy;
  logic                       r_drop;

  logic             w_start;
  logic             w_drop;
  logic             w_issue;
  logic             w_busy;
  logic             w_last;
  logic [IN_W-1:0]  w_x;
  logic             w_ov;
  tag_t             w_otag;
  logic [OUT_W-1:0] w_ores;
  logic             w_oz;

  log2_ln_core #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .FRAC_W   (FRAC_W),
    .LUT_BITS (LUT_BITS)
  ) u_core (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_valid (w_issue),
    .i_tag   (r_cnt),
    .i_x     (w_x),
    .o_valid (w_ov),
    .o_tag   (w_otag),
    .o_res   (w_ores),
    .o_zero  (w_oz)
  );

  assign w_last = w_ov && (w_otag == tag_t'(N_CH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.mel_ready) w_next = RUN;
      RUN:     if (r_cnt == tag_t'(N_CH - 1)) w_next = DRAIN;
      DRAIN:   if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // busy also covers the ready cycle, when the FSM is already idle.
  always_comb begin
    w_start = (r_state == IDLE) && bus.mel_ready;
    w_drop  = (r_state != IDLE) && bus.mel_ready;
    w_issue = (r_state == RUN);
    w_busy  = (r_state != IDLE) || r_rdy;
  end

  always_comb begin
    w_x = '0;
    for (int i = 0; i < N_CH; i++)
      if (r_cnt == tag_t'(i)) w_x = r_cap[i];
  end

  always_comb begin
    w_shd  = r_shd;
    w_zshd = r_zshd;
    for (int i = 0; i < N_CH; i++)
      if (w_ov && (w_otag == tag_t'(i))) begin
        w_shd[i]  = w_ores;
        w_zshd[i] = w_oz;
      end
  end

  // The last channel is folded in straight from the core output so the
  // whole frame becomes visible in one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_cap  <= '0;
      r_shd  <= '0;
      r_zshd <= '0;
      r_out  <= '0;
      r_zout <= '0;
      r_rdy  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (w_start) begin
        r_cap <= bus.mel_in;
        r_cnt <= '0;
      end else if (w_issue) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_shd  <= w_shd;
      r_zshd <= w_zshd;
      r_rdy  <= w_last;
      if (w_last) begin
        r_out  <= w_shd;
        r_zout <= w_zshd;
      end
      if (w_drop) r_drop <= 1'b1;
    end
  end

  assign bus.log_out   = r_out;
  assign bus.zero_flag = r_zout;
  assign bus.log_ready = r_rdy;
  assign bus.busy      = w_busy;
  assign bus.drop_err  = r_drop;

endmodule

// File: tb/tb_log_mel_engine.sv
// Scoreboard bench for log_mel_engine: directed frames and random ln.
// Tolerance follows the LOG_INTERP_EN build.
module tb_log_mel_engine;
  localparam int N_CH  = 13;
  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
`ifdef LOG_INTERP_EN
  localparam int TOL = 1;
`else
  // nearest-lower LUT step is worth up to ~7.9 output LSB near 1.0
  localparam int TOL = 8;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  log_mel_engine_if #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W)) bus();

  log_mel_engine dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [N_CH-1:0][15:0] v;
    logic [N_CH-1:0][3:0]  tol;
    logic [N_CH-1:0]       z;
    int                    cyc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act,
                     input int exp, input int tol);
    n_cmp++;
    if (act < exp - tol || act > exp + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)",
               nm, act, exp, tol);
    end
  endtask

  function automatic int ref_ln(input int x);
    if (x == 0) return 0;
    return int'($ln(real'(x)) * 256.0);
  endfunction

  // call at a negedge; capture happens on the next posedge
  task automatic issue(input logic [N_CH-1:0][IN_W-1:0] x,
                       input logic [N_CH-1:0][15:0] e,
                       input logic [N_CH-1:0][3:0] t);
    exp_t ex;
    ex.v   = e;
    ex.tol = t;
    ex.cyc = cyc + N_CH + 4;
    for (int i = 0; i < N_CH; i++) ex.z[i] = (x[i] == '0);
    sb.push_back(ex);
    bus.mel_in    = x;
    bus.mel_ready = 1'b1;
    @(negedge clk);
    bus.mel_ready = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.log_ready && k < 40);
    chk("log_ready_seen", int'(bus.log_ready), 1, 0);
    chk("busy_in_ready_cycle", int'(bus.busy), 1, 0);
  endtask

  always @(negedge clk) begin
    exp_t ex;
    if (reset_n && bus.log_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_log_ready", 1, 0, 0);
      end else begin
        ex = sb.pop_front();
        chk("latency_cycle", cyc, ex.cyc, 0);
        for (int i = 0; i < N_CH; i++)
          chk($sformatf("log_out[%0d]", i), int'(bus.log_out[i]),
              int'(ex.v[i]), int'(ex.tol[i]));
        chk("zero_flag", int'(bus.zero_flag), int'(ex.z), 0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int ramp_e[N_CH] = '{0, 177, 355, 532, 710, 887, 1065,
                       1242, 1420, 1597, 1774, 1952, 2129};
  int seq_e[N_CH]  = '{0, 177, 281, 355, 412, 459, 498,
                       532, 562, 589, 614, 636, 657};

  logic [N_CH-1:0][IN_W-1:0] rx, zx, sx, gx;
  logic [N_CH-1:0][15:0]     re, ze, se, ge;
  logic [N_CH-1:0][3:0]      rt, zt, st, gt;

  initial begin
    bus.mel_in    = '0;
    bus.mel_ready = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      rx[i] = IN_W'(1) << i;
      re[i] = 16'(ramp_e[i]);
      rt[i] = 4'd1;
      zx[i] = (i == 4) ? '0 : 16'hFFFF;
      ze[i] = (i == 4) ? 16'd0 : 16'd2839;
      zt[i] = (i == 4) ? 4'd0 : 4'(TOL);
      sx[i] = IN_W'(i + 1);
      se[i] = 16'(seq_e[i]);
      st[i] = (i == 0 || i == 1 || i == 3 || i == 7) ? 4'd1 : 4'(TOL);
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < N_CH; i++)
      chk("reset_log_out", int'(bus.log_out[i]), 0, 0);
    chk("reset_zero_flag", int'(bus.zero_flag), 0, 0);
    chk("reset_log_ready", int'(bus.log_ready), 0, 0);
    chk("reset_busy", int'(bus.busy), 0, 0);
    chk("reset_drop_err", int'(bus.drop_err), 0, 0);
    reset_n = 1'b1;
    @(negedge clk);

    issue(rx, re, rt);
    chk("busy_after_capture", int'(bus.busy), 1, 0);
    wait_done();
    @(negedge clk);
    chk("busy_idle", int'(bus.busy), 0, 0);
    chk("log_ready_pulse", int'(bus.log_ready), 0, 0);

    issue(zx, ze, zt);
    wait_done();
    chk("zero_flag_ch4", int'(bus.zero_flag), 13'h0010, 0);

    issue(sx, se, st);
    wait_done();
    issue(rx, re, rt);
    wait_done();
    chk("b2b_no_drop", int'(bus.drop_err), 0, 0);

    issue(rx, re, rt);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < N_CH; i++)
      chk("midreset_log_out", int'(bus.log_out[i]), 0, 0);
    chk("midreset_zero_flag", int'(bus.zero_flag), 0, 0);
    chk("midreset_busy", int'(bus.busy), 0, 0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("midreset_no_ready", int'(bus.log_out[12]), 0, 0);
    issue(sx, se, st);
    wait_done();

    issue(sx, se, st);
    repeat (4) @(negedge clk);
    bus.mel_in    = '1;
    bus.mel_ready = 1'b1;
    @(negedge clk);
    bus.mel_ready = 1'b0;
    chk("drop_err_set", int'(bus.drop_err), 1, 0);
    wait_done();

    for (int f = 0; f < 770; f++) begin
      for (int i = 0; i < N_CH; i++) begin
        int sel;
        int v;
        sel = int'($urandom_range(0, 9));
        if (sel == 0)      v = 0;
        else if (sel < 4)  v = int'($urandom_range(1, 255));
        else               v = int'($urandom_range(1, 65535));
        gx[i] = IN_W'(v);
        ge[i] = 16'(ref_ln(v));
        gt[i] = (v == 0) ? 4'd0 : 4'(TOL);
      end
      issue(gx, ge, gt);
      wait_done();
    end
    @(negedge clk);
    chk("drop_err_sticky", int'(bus.drop_err), 1, 0);
    chk("scoreboard_empty", sb.size(), 0, 0);

    reset_n = 1'b0;
    #1;
    chk("drop_err_cleared", int'(bus.drop_err), 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
